// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//
// I2S transmitter for the CS4272 SDin pin. It takes processed stereo samples
// from the equalizer/volume datapath and shifts them out MSB-first. Bit and
// frame timing follow sclk/lrclk. Both come from the clock generator in the
// clk domain, so they are edge-detected directly and not synchronised.
//
// Each channel slot is SLOT_W sclk periods long:
//   slot 0            : 0 (I2S one-bit delay)
//   slots 1..CODEC_W  : {sample, (CODEC_W-DATA_W) zeros}, MSB first
//   remaining slots   : 0
//
// The design is double-buffered. A holding pair is written by vld. At each
// left frame start the holding pair becomes the active pair. At the same
// moment req pulses so that upstream can deliver the next pair. If no new
// pair arrived in time, the previous pair is sent again.
//
// Optional feature (macro I2S_TX_UNDERRUN_CNT_EN):
//   Adds the output underrun_cnt[7:0]. It is a saturating count of synced left
//   frame starts that found no fresh pair. Only reset clears it.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset
//   sclk         in   serial bit clock (clk/32), clk-domain generated
//   lrclk        in   word select, 0 = left, 1 = right; changes on sclk fall
//   lft_in       in   left sample (signed, DATA_W)
//   rht_in       in   right sample (signed, DATA_W)
//   vld          in   one-clk strobe qualifying lft_in/rht_in
//   req          out  one-clk pulse: holding pair consumed
//   SDin         out  registered serial data to the codec
//   underrun_cnt out  underrun counter (only with I2S_TX_UNDERRUN_CNT_EN)
// -----------------------------------------------------------------------------
module i2s_tx #(
    parameter int DATA_W  = 16,
    parameter int CODEC_W = 24,
    parameter int SLOT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic              vld,
    output logic              req,
    output logic              SDin
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_cnt
`endif
);

    localparam int PAD_W  = CODEC_W - DATA_W;
    localparam int TAIL_W = SLOT_W - 1 - CODEC_W;

    // Builds a full channel slot: delay bit, codec word, trailing zeros.
    function automatic logic [SLOT_W-1:0] build_slot(input logic [DATA_W-1:0] sample);
        logic [CODEC_W-1:0] codec_word;
        logic [SLOT_W-1:0]  word;
        codec_word = {sample, {PAD_W{1'b0}}};
        word       = {1'b0, codec_word, {TAIL_W{1'b0}}};
        return word;
    endfunction

    // Edge-detect and frame state
    logic              sclk_q_r;
    logic              lr_prev_r;
    logic              synced_r;
    logic              pending_r;

    // Data path
    logic [DATA_W-1:0] lft_hold_r;
    logic [DATA_W-1:0] rht_hold_r;
    logic [DATA_W-1:0] rht_act_r;
    logic [SLOT_W-1:0] shift_r;
    logic [SLOT_W-1:0] shift_nxt_s;

    // Outputs
    logic              sdin_r;
    logic              req_r;

    // Decoded events
    logic              fall_s;
    logic              lr_change_s;
    logic              left_start_s;
    logic              right_start_s;

    // Event decode. A right start counts only once a left start has aligned us.
    always_comb begin
        fall_s        = sclk_q_r & ~sclk;
        lr_change_s   = fall_s & (lrclk != lr_prev_r);
        left_start_s  = lr_change_s & ~lrclk;
        right_start_s = lr_change_s & lrclk & synced_r;
    end

    // Next shift-register value: reload at slot starts, shift on other falls.
    always_comb begin
        shift_nxt_s = shift_r;
        if (left_start_s) begin
            shift_nxt_s = build_slot(lft_hold_r);
        end else if (right_start_s) begin
            shift_nxt_s = build_slot(rht_act_r);
        end else if (fall_s) begin
            shift_nxt_s = {shift_r[SLOT_W-2:0], 1'b0};
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // sclk history and the lrclk value seen at the last sclk fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q_r  <= 1'b0;
            lr_prev_r <= 1'b0;
        end else begin
            sclk_q_r <= sclk;
            if (fall_s) begin
                lr_prev_r <= lrclk;
            end else begin
                lr_prev_r <= lr_prev_r;
            end
        end
    end

    // Frame alignment flag. It sets at the first left start after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced_r <= 1'b0;
        end else if (left_start_s) begin
            synced_r <= 1'b1;
        end else begin
            synced_r <= synced_r;
        end
    end

    // Holding pair and pending flag. If vld coincides with a left start, vld
    // wins: the transfer has already taken the old pair, so the new pair
    // stays pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_hold_r <= {DATA_W{1'b0}};
            rht_hold_r <= {DATA_W{1'b0}};
            pending_r  <= 1'b0;
        end else if (vld) begin
            lft_hold_r <= lft_in;
            rht_hold_r <= rht_in;
            pending_r  <= 1'b1;
        end else if (left_start_s) begin
            lft_hold_r <= lft_hold_r;
            rht_hold_r <= rht_hold_r;
            pending_r  <= 1'b0;
        end else begin
            lft_hold_r <= lft_hold_r;
            rht_hold_r <= rht_hold_r;
            pending_r  <= pending_r;
        end
    end

    // Active right sample, captured with the left one so both halves of a
    // frame come from the same pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rht_act_r <= {DATA_W{1'b0}};
        end else if (left_start_s) begin
            rht_act_r <= rht_hold_r;
        end else begin
            rht_act_r <= rht_act_r;
        end
    end

    // Serial shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {SLOT_W{1'b0}};
        end else begin
            shift_r <= shift_nxt_s;
        end
    end

    // Registered outputs. SDin follows the shift MSB one clk later, which is
    // still far ahead of the next sclk rise. Before sync it is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdin_r <= 1'b0;
            req_r  <= 1'b0;
        end else begin
            sdin_r <= synced_r & shift_r[SLOT_W-1];
            req_r  <= left_start_s;
        end
    end

    assign SDin = sdin_r;
    assign req  = req_r;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt_r;

    // Saturating count of synced left starts with no fresh pair waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_r <= 8'h00;
        end else if (left_start_s && synced_r && !pending_r && (underrun_cnt_r != 8'hFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 8'h01;
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
//
// Self-checking bench for i2s_tx.
//
// A free-running tick counter produces sclk = clk/32 and lrclk = sclk/64.
// Tick 0 is the start of a left frame.
//
// The reference model works frame by frame. At every left frame start after
// reset it queues the two expected slot words, taken from the pair it holds.
// It then applies any vld that arrives in that same cycle.
//
// A monitor samples SDin once per sclk high phase. It assembles 32-bit slot
// words and compares each word with the queue. If the queue is empty, the
// expected word is 0.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] lft_in = 16'h0000;
    logic [15:0] rht_in = 16'h0000;
    logic        req;
    logic        SDin;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] tick = 11'd0;

    i2s_tx dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .lrclk  (lrclk),
        .lft_in (lft_in),
        .rht_in (rht_in),
        .vld    (vld),
        .req    (req),
        .SDin   (SDin)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_lft = 16'h0000;
    logic [15:0] m_rht = 16'h0000;
    bit          m_pend = 1'b0;
    bit          m_sync = 1'b0;
    int          m_under = 0;
    logic        exp_req = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        exp_req = 1'b0;
        if (!rst_n) begin
            m_lft = 16'h0000;
            m_rht = 16'h0000;
            m_pend = 1'b0;
            m_sync = 1'b0;
            m_under = 0;
            exp_q.delete();
        end else begin
            if (tick == 11'd0) begin
                exp_req = 1'b1;
                if (m_sync && !m_pend && m_under < 255) m_under++;
                m_sync = 1'b1;
                // Slot word: delay bit, 16-bit sample, 8 pad zeros, 7 tail zeros.
                exp_q.push_back(32'(m_lft) << 15);
                exp_q.push_back(32'(m_rht) << 15);
                m_pend = 1'b0;
            end
            if (vld) begin
                m_lft = lft_in;
                m_rht = rht_in;
                m_pend = 1'b1;
            end
        end
    end

    // ---------------- monitor + timing generator ----------------
    logic [31:0] acc = 32'd0;
    logic [31:0] exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc = 32'd0;
        end else if (tick[4:0] == 5'd16) begin
            acc = {acc[30:0], SDin};
            if (tick[9:5] == 5'd31) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
                vectors++;
                if (acc !== exp_w) begin
                    miscompares++;
                    $display("FAIL slot_%s: got %h expected %h at %0t",
                             tick[10] ? "right" : "left", acc, exp_w, $time);
                end
`ifdef I2S_TX_UNDERRUN_CNT_EN
                vectors++;
                if (underrun_cnt !== 8'(m_under)) begin
                    miscompares++;
                    $display("FAIL underrun_cnt: got %0d expected %0d", underrun_cnt, m_under);
                end
`endif
            end
        end
        if (req === 1'b1 || exp_req === 1'b1) begin
            vectors++;
            if (req !== exp_req) begin
                miscompares++;
                $display("FAIL req: got %b expected %b at %0t", req, exp_req, $time);
            end
        end
        tick  = tick + 11'd1;
        sclk  = tick[4];
        lrclk = tick[10];
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just before the posedge at which the DUT sees tick == t.
    task automatic wait_to(input logic [10:0] t);
        int n;
        n = 0;
        step();
        while (tick != t && n < 4200) begin
            step();
            n++;
        end
        if (tick != t) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_to: tick %0d never reached %0d", tick, t);
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        lft_in = l;
        rht_in = r;
        vld = 1'b1;
        step();
        vld = 1'b0;
    endtask

    initial begin
        logic [10:0] t;
        // Release reset mid right slot; output must stay quiet until tick 0.
        wait_to(11'd1500);
        rst_n = 1'b1;

        // First frame sends 0/0; load the boundary pair for the next frame.
        wait_to(11'd100);
        send(16'h8001, 16'h7FFE);

        // One pair, then no vld for three frames.
        wait_to(11'd200);
        send(16'h1234, 16'hABCD);
        repeat (4) wait_to(11'd0);

        // Keep something pending, then write exactly at a left frame start.
        wait_to(11'd300);
        send(16'h5555, 16'hAAAA);
        wait_to(11'd0);
        send(16'h0F0F, 16'hF0F0);

        // Two writes in one frame; the last write wins.
        wait_to(11'd0);
        wait_to(11'd100);
        send(16'h0001, 16'h1111);
        wait_to(11'd600);
        send(16'h0002, 16'h2222);

        // Randomised writes at arbitrary points in the frame.
        for (int i = 0; i < 6; i++) begin
            t = 11'($urandom_range(0, 2047));
            wait_to(t);
            send(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) send(16'($urandom), 16'($urandom));
        end

        // Async reset while right-slot data ones are shifting out.
        wait_to(11'd500);
        send(16'h0000, 16'hFFFF);
        wait_to(11'd0);
        wait_to(11'd1300);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (SDin !== 1'b0 || req !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got SDin=%b req=%b expected 0/0", SDin, req);
        end
        repeat (5) step();
        wait_to(11'd1400);
        rst_n = 1'b1;

        // Resume: 0/0 frame, then a fresh random pair.
        wait_to(11'd500);
        send(16'($urandom), 16'($urandom));
        wait_to(11'd0);
        wait_to(11'd0);
        wait_to(11'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
